// File: rtl/prog_loader.sv
// prog_loader
// -----------
// Upstream program-load stage for the tiny accumulator core. A host pushes
// IMEM_SZ program bytes followed by one checksum byte over an 8-bit pin bus
// using a 4-phase strobe/ack handshake. Each program byte becomes a single
// imem write cycle. The core is held in reset while a load is in progress.
// It is released only when the bytes plus the checksum sum to zero mod 2^INST_W.
//
// Handshake (host <-> loader, 4-phase):
//   host drives data_in, raises strobe_in; loader captures the byte and
//   raises ack_out; host drops strobe_in; loader drops ack_out once the
//   synchronized strobe is seen low; host may then start the next byte.
//   data_in must stay stable from the strobe rise until ack_out is seen high.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   load_req_in     async pin, rising edge starts/restarts a load session
//   strobe_in       async pin, host data-valid (4-phase)
//   data_in         async pin bus, captured when a strobe rise is detected
//   ack_out         handshake acknowledge to host
//   imem_we_out     one-cycle imem write enable per program byte
//   imem_waddr_out  imem write address (0..IMEM_SZ-1, in order)
//   imem_wdata_out  imem write data
//   core_run_out    1 = core runs, 0 = core held in reset
//   status_out      00 IDLE, 01 LOAD/CHECK, 10 RUN, 11 ERROR (FSM debug view)
//   byte_cnt_out    bytes accepted this session, 0..IMEM_SZ+1
module prog_loader #(
  parameter int IMEM_SZ     = 16,
  parameter int INST_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit AUTO_RUN    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req_in,
  input  logic              strobe_in,
  input  logic [INST_W-1:0] data_in,
  output logic              ack_out,
  output logic              imem_we_out,
  output logic [3:0]        imem_waddr_out,
  output logic [INST_W-1:0] imem_wdata_out,
  output logic              core_run_out,
  output logic [1:0]        status_out,
  output logic [4:0]        byte_cnt_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_RUN,
    S_ERROR
  } state_t;

  localparam state_t     RST_STATE = AUTO_RUN ? S_RUN : S_IDLE;
  localparam logic [4:0] CNT_LAST  = 5'(IMEM_SZ);
  localparam logic [4:0] CNT_DONE  = 5'(IMEM_SZ + 1);

  // ---------------------------------------------------------------------------
  // Input synchronizers. Each pin goes through SYNC_STAGES flops; the last
  // stage is compared with its previous value and the rise is registered, so
  // a pin rise is seen as a one-cycle pulse SYNC_STAGES+1 cycles later.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] load_sync;
  logic [SYNC_STAGES-1:0] strb_sync;
  logic                   load_last;
  logic                   strb_last;
  logic                   load_rise;
  logic                   strb_rise;
  logic                   strb_level;

  assign strb_level = strb_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_sync <= '0;
      strb_sync <= '0;
      load_last <= 1'b0;
      strb_last <= 1'b0;
      load_rise <= 1'b0;
      strb_rise <= 1'b0;
    end else begin
      load_sync <= {load_sync[SYNC_STAGES-2:0], load_req_in};
      strb_sync <= {strb_sync[SYNC_STAGES-2:0], strobe_in};
      load_last <= load_sync[SYNC_STAGES-1];
      strb_last <= strb_level;
      load_rise <= load_sync[SYNC_STAGES-1] & ~load_last;
      strb_rise <= strb_level & ~strb_last;
    end
  end

  // ---------------------------------------------------------------------------
  // Session FSM: state register
  // ---------------------------------------------------------------------------
  state_t            state, state_n;
  logic [4:0]        count, count_n;
  logic [INST_W-1:0] sum, sum_n;
  logic              ack_n;
  logic              we_n;
  logic [3:0]        waddr_n;
  logic [INST_W-1:0] wdata_n;
  logic              run_n;
  logic [4:0]        count_inc;
  logic [INST_W-1:0] sum_add;

  assign count_inc = count + 5'd1;
  assign sum_add   = sum + data_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RST_STATE;
      count          <= '0;
      sum            <= '0;
      ack_out        <= 1'b0;
      imem_we_out    <= 1'b0;
      imem_waddr_out <= '0;
      imem_wdata_out <= '0;
      core_run_out   <= AUTO_RUN;
    end else begin
      state          <= state_n;
      count          <= count_n;
      sum            <= sum_n;
      ack_out        <= ack_n;
      imem_we_out    <= we_n;
      imem_waddr_out <= waddr_n;
      imem_wdata_out <= wdata_n;
      core_run_out   <= run_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Session FSM: next state and registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    count_n = count;
    sum_n   = sum;
    // ack falls once the synchronized strobe has been seen low
    ack_n   = ack_out & strb_level;
    we_n    = 1'b0;
    waddr_n = imem_waddr_out;
    wdata_n = imem_wdata_out;

    if (load_rise) begin
      // A load request wins over everything, including a coincident strobe.
      state_n = S_LOAD;
      count_n = '0;
      sum_n   = '0;
      ack_n   = 1'b0;
    end else if (strb_rise) begin
      case (state)
        S_LOAD: begin
          we_n    = 1'b1;
          waddr_n = count[3:0];
          wdata_n = data_in;
          sum_n   = sum_add;
          count_n = count_inc;
          ack_n   = 1'b1;
          if (count_inc == CNT_LAST) state_n = S_CHECK;
        end
        S_CHECK: begin
          count_n = CNT_DONE;
          ack_n   = 1'b1;
          state_n = (sum_add == '0) ? S_RUN : S_ERROR;
        end
        default: ;  // strobes outside a session are ignored
      endcase
    end

    run_n = (state_n == S_RUN);
  end

  always_comb begin
    status_out = 2'b00;
    case (state)
      S_IDLE:          status_out = 2'b00;
      S_LOAD, S_CHECK: status_out = 2'b01;
      S_RUN:           status_out = 2'b10;
      S_ERROR:         status_out = 2'b11;
      default:         status_out = 2'b00;
    endcase
  end

  assign byte_cnt_out = count;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader (SYNC_STAGES=2). A second instance with
// AUTO_RUN=0 shares the inputs and is only inspected for its reset state.
module tb_prog_loader;

  localparam int S = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       load_req = 1'b0;
  logic       strobe = 1'b0;
  logic [7:0] data = 8'h00;

  logic       ack, we, core_run;
  logic [3:0] waddr;
  logic [7:0] wdata;
  logic [1:0] status;
  logic [4:0] byte_cnt;

  logic       ack0, we0, core_run0;
  logic [3:0] waddr0;
  logic [7:0] wdata0;
  logic [1:0] status0;
  logic [4:0] byte_cnt0;

  prog_loader #(.IMEM_SZ(16), .INST_W(8), .SYNC_STAGES(S), .AUTO_RUN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .load_req_in(load_req), .strobe_in(strobe),
    .data_in(data), .ack_out(ack), .imem_we_out(we), .imem_waddr_out(waddr),
    .imem_wdata_out(wdata), .core_run_out(core_run), .status_out(status),
    .byte_cnt_out(byte_cnt)
  );

  prog_loader #(.IMEM_SZ(16), .INST_W(8), .SYNC_STAGES(S), .AUTO_RUN(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .load_req_in(load_req), .strobe_in(strobe),
    .data_in(data), .ack_out(ack0), .imem_we_out(we0), .imem_waddr_out(waddr0),
    .imem_wdata_out(wdata0), .core_run_out(core_run0), .status_out(status0),
    .byte_cnt_out(byte_cnt0)
  );

  // program image; these 16 bytes sum to 0x8D, so 0x73 is the good checksum
  logic [7:0] prog [16] = '{8'h1B, 8'h17, 8'h1B, 8'h37, 8'hFB, 8'h07, 8'h11, 8'h20,
                            8'h27, 8'h03, 8'h36, 8'h07, 8'h6F, 8'h00, 8'h00, 8'h00};
  localparam logic [7:0] CK_GOOD = 8'h73;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: observed writes vs expected {addr,data}
  logic [11:0] wr_q[$];
  logic [11:0] exp_q[$];
  int   ack_rises = 0;
  int   dbl_we = 0;
  logic we_prev = 1'b0;
  logic ack_prev = 1'b0;

  always @(negedge clk) begin
    if (we) wr_q.push_back({waddr, wdata});
    if (we && we_prev) dbl_we <= dbl_we + 1;
    if (ack && !ack_prev) ack_rises <= ack_rises + 1;
    we_prev  <= we;
    ack_prev <= ack;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_load();
    @(negedge clk);
    load_req = 1'b1;
    tick(3);
    load_req = 1'b0;
    tick(5);
  endtask

  task automatic send_byte(input logic [7:0] b, output int lat, output logic we_at_ack);
    lat = 0;
    we_at_ack = 1'b0;
    @(negedge clk);
    data = b;
    strobe = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ack) begin
        lat = i;
        we_at_ack = we;
        break;
      end
    end
    if (lat == 0) check("ack_timeout", {31'd0, ack}, 32'd1);
    strobe = 1'b0;
    for (int i = 0; i < 20 && ack; i++) @(negedge clk);
    if (ack) check("ack_release", {31'd0, ack}, 32'd0);
  endtask

  int lat_first;
  int lat_bad;

  task automatic send_prog(input logic [7:0] ck);
    int   lat;
    logic w;
    exp_q.delete();
    wr_q.delete();
    lat_bad = 0;
    for (int i = 0; i < 16; i++) begin
      send_byte(prog[i], lat, w);
      if (i == 0) lat_first = lat;
      if (lat != S + 2 || !w) lat_bad++;
      exp_q.push_back({4'(i), prog[i]});
    end
    send_byte(ck, lat, w);
    check("ck_no_we", {31'd0, w}, 32'd0);
    tick(4);
  endtask

  task automatic verify_writes(input string tag);
    check({tag, "_nwr"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check({tag, "_wr"}, {20'd0, wr_q[i]}, {20'd0, exp_q[i]});
  endtask

  logic [7:0] bad_ck [2] = '{8'h83, 8'h84};

  initial begin
    int   a0, d, lat;
    logic w;

    // reset state
    tick(2);
    check("rst_status", status, 2'b10);
    check("rst_run", core_run, 1);
    check("rst_we", we, 0);
    check("rst_ack", ack, 0);
    check("rst_cnt", byte_cnt, 0);
    check("rst0_status", status0, 2'b00);
    check("rst0_run", core_run0, 0);
    rst_n = 1'b1;
    tick(3);

    // strobe while running is ignored
    wr_q.delete();
    a0 = ack_rises;
    @(negedge clk);
    data = 8'h5A;
    strobe = 1'b1;
    tick(10);
    strobe = 1'b0;
    tick(6);
    check("run_strb_nwr", wr_q.size(), 0);
    check("run_strb_ack", ack_rises - a0, 0);
    check("run_strb_status", status, 2'b10);

    // good load
    start_load();
    check("load_status", status, 2'b01);
    check("load_run", core_run, 0);
    a0 = ack_rises;
    send_prog(CK_GOOD);
    verify_writes("good");
    check("good_lat_first", lat_first, S + 2);
    check("good_lat_bad", lat_bad, 0);
    check("good_acks", ack_rises - a0, 17);
    check("good_cnt", byte_cnt, 17);
    check("good_status", status, 2'b10);
    check("good_run", core_run, 1);

    // bad checksums
    for (int k = 0; k < 2; k++) begin
      start_load();
      send_prog(bad_ck[k]);
      verify_writes("bad");
      check("bad_cnt", byte_cnt, 17);
      check("bad_status", status, 2'b11);
      check("bad_run", core_run, 0);
    end

    // restart mid-load
    start_load();
    for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i), lat, w);
    check("part_cnt", byte_cnt, 5);
    start_load();
    check("restart_cnt", byte_cnt, 0);
    check("restart_status", status, 2'b01);
    send_prog(CK_GOOD);
    verify_writes("restart");
    check("restart_status_end", status, 2'b10);

    // strobe held high for 40 cycles
    start_load();
    wr_q.delete();
    a0 = ack_rises;
    @(negedge clk);
    data = 8'hA5;
    strobe = 1'b1;
    tick(40);
    strobe = 1'b0;
    d = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (!ack) begin
        d = i;
        break;
      end
    end
    check("hold_ack_drop", {31'd0, (d >= S + 1 && d <= S + 2)}, 1);
    check("hold_nwr", wr_q.size(), 1);
    if (wr_q.size() > 0) check("hold_wr", {20'd0, wr_q[0]}, {20'd0, 4'd0, 8'hA5});
    check("hold_acks", ack_rises - a0, 1);
    check("hold_cnt", byte_cnt, 1);

    // reset during byte 8
    start_load();
    for (int i = 0; i < 7; i++) send_byte(prog[i], lat, w);
    @(negedge clk);
    data = prog[7];
    strobe = 1'b1;
    tick(3);
    @(posedge clk);
    #2;
    check("mid_pre_we", we, 1);
    rst_n = 1'b0;
    #1;
    check("mid_we", we, 0);
    check("mid_ack", ack, 0);
    check("mid_waddr", waddr, 0);
    check("mid_wdata", wdata, 0);
    check("mid_cnt", byte_cnt, 0);
    check("mid_status", status, 2'b10);
    check("mid_run", core_run, 1);
    strobe = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    check("dbl_we", dbl_we, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
